// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch queue: issues one word fetch at a time to a variable-latency memory.
// It buffers returned words with their PC and hands them to decode in order; a redirect flushes the queue.
module inst_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     CLK,
    input  logic                     RESET,
    output logic                     Mem_req,
    output logic [31:0]              Mem_addr,
    input  logic                     Mem_gnt,
    input  logic                     Mem_rvalid,
    input  logic [31:0]              Mem_rdata,
    input  logic                     Redirect,
    input  logic [31:0]              Redirect_PC,
    output logic                     Inst_valid,
    output logic [31:0]              Instruction,
    output logic [31:0]              Inst_PC,
    input  logic                     Inst_ready,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [31:0]     r_fetchPc;
    logic [31:0]     r_reqPc;
    logic [PW-1:0]   r_rdPtr;
    logic [PW-1:0]   r_wrPtr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_instMem [DEPTH];
    logic [31:0]     r_pcMem   [DEPTH];

    logic            w_grant;
    logic            w_push;
    logic            w_pop;

    // Mem_req is also held low while reset is asserted so the interface is quiet during reset.
    assign Mem_req     = (r_state == S_IDLE) && (r_count < CW'(DEPTH)) && !Redirect && !RESET;
    assign Mem_addr    = r_fetchPc;
    assign w_grant     = Mem_req && Mem_gnt;
    assign w_push      = (r_state == S_WAIT) && Mem_rvalid && !Redirect;
    assign w_pop       = (r_count != '0) && Inst_ready && !Redirect;
    assign Inst_valid  = (r_count != '0);
    assign Instruction = r_instMem[r_rdPtr];
    assign Inst_PC     = r_pcMem[r_rdPtr];
    assign Count       = r_count;

    always_comb begin
        w_nextState = r_state;
        if (Redirect) begin
            // A request still in flight must have its response swallowed later.
            if ((r_state == S_WAIT || r_state == S_DRAIN) && !Mem_rvalid)
                w_nextState = S_DRAIN;
            else
                w_nextState = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  if (w_grant)    w_nextState = S_WAIT;
                S_WAIT:  if (Mem_rvalid) w_nextState = S_IDLE;
                S_DRAIN: if (Mem_rvalid) w_nextState = S_IDLE;
                default: w_nextState = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            r_state <= S_IDLE;
        else
            r_state <= w_nextState;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_fetchPc <= RESET_PC;
            r_reqPc   <= '0;
            r_rdPtr   <= '0;
            r_wrPtr   <= '0;
            r_count   <= '0;
        end else if (Redirect) begin
            r_fetchPc <= Redirect_PC;
            r_rdPtr   <= '0;
            r_wrPtr   <= '0;
            r_count   <= '0;
        end else begin
            if (w_grant) begin
                r_reqPc   <= r_fetchPc;
                r_fetchPc <= r_fetchPc + 32'd4;
            end
            if (w_push)
                r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)
                r_rdPtr <= r_rdPtr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_instMem[i] <= '0;
                r_pcMem[i]   <= '0;
            end
        end else if (w_push) begin
            r_instMem[r_wrPtr] <= Mem_rdata;
            r_pcMem[r_wrPtr]   <= r_reqPc;
        end
    end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Self-checking bench for inst_prefetch_buffer: fixed vector table, hand-written corner cases,
// and randomized traffic compared against a queue-based reference of the fetch stage.
module tb_inst_prefetch_buffer;

    localparam int DEPTH = 4;
    localparam bit T = 1'b1;
    localparam bit F = 1'b0;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        Mem_req;
    logic [31:0] Mem_addr;
    logic        Mem_gnt;
    logic        Mem_rvalid;
    logic [31:0] Mem_rdata;
    logic        Redirect;
    logic [31:0] Redirect_PC;
    logic        Inst_valid;
    logic [31:0] Instruction;
    logic [31:0] Inst_PC;
    logic        Inst_ready;
    logic [2:0]  Count;

    int nChecks = 0;
    int nFail   = 0;

    inst_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .RESET(RESET),
        .Mem_req(Mem_req), .Mem_addr(Mem_addr), .Mem_gnt(Mem_gnt),
        .Mem_rvalid(Mem_rvalid), .Mem_rdata(Mem_rdata),
        .Redirect(Redirect), .Redirect_PC(Redirect_PC),
        .Inst_valid(Inst_valid), .Instruction(Instruction), .Inst_PC(Inst_PC),
        .Inst_ready(Inst_ready), .Count(Count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] ePc;
        logic [31:0] eInst;
        logic [2:0]  eCount;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    // Reference: the queue holds decoded-order entries; a pending request is tracked as a flag
    // plus a "stale" marker for responses that must vanish after a flush.
    entry_t      q[$];
    logic [31:0] mFetchPc;
    logic [31:0] mReqPc;
    bit          mOut;
    bit          mStale;
    int          mDelay;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic gnt, input logic rv, input logic [31:0] rdata,
                                 input logic ready, input logic redir, input logic [31:0] rpc);
        Mem_gnt     = gnt;
        Mem_rvalid  = rv;
        Mem_rdata   = rdata;
        Inst_ready  = ready;
        Redirect    = redir;
        Redirect_PC = rpc;
    endtask

    task automatic modelReset();
        q.delete();
        mFetchPc = 32'h0;
        mReqPc   = 32'h0;
        mOut     = 1'b0;
        mStale   = 1'b0;
        mDelay   = 0;
    endtask

    task automatic doReset();
        @(negedge CLK);
        applyStimulus(F, F, 32'h0, F, F, 32'h0);
        RESET = 1'b1;
        #1;
        checkOutput("rst_req",   32'(Mem_req), 32'h0);
        checkOutput("rst_addr",  Mem_addr, 32'h0);
        checkOutput("rst_valid", 32'(Inst_valid), 32'h0);
        checkOutput("rst_count", 32'(Count), 32'h0);
        checkOutput("rst_inst",  Instruction, 32'h0);
        checkOutput("rst_pc",    Inst_PC, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        modelReset();
    endtask

    // One cycle of randomized traffic: memory responder, DUT compare, then reference update.
    task automatic runCycles(input int n, input int gntPct, input int readyPct, input int redirPct);
        for (int c = 0; c < n; c++) begin
            logic        gnt, rv, ready, redir, eReq, grant, doPush;
            logic [31:0] rdata, rpc;
            entry_t      e;
            @(negedge CLK);
            gnt   = ($urandom_range(99) < gntPct);
            ready = ($urandom_range(99) < readyPct);
            redir = ($urandom_range(99) < redirPct);
            rpc   = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_FFFC);
            rv    = 1'b0;
            rdata = $urandom();
            if (mOut && mDelay == 0) begin
                rv    = 1'b1;
                rdata = memWord(mReqPc);
            end else if (!mOut && $urandom_range(9) == 0) begin
                rv = 1'b1;
            end
            applyStimulus(gnt, rv, rdata, ready, redir, rpc);
            #1;
            eReq = !mOut && (q.size() < DEPTH) && !redir;
            checkOutput("rnd_req",   32'(Mem_req), 32'(eReq));
            checkOutput("rnd_addr",  Mem_addr, mFetchPc);
            checkOutput("rnd_count", 32'(Count), 32'(q.size()));
            checkOutput("rnd_valid", 32'(Inst_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                checkOutput("rnd_pc",   Inst_PC, q[0].pc);
                checkOutput("rnd_inst", Instruction, q[0].inst);
            end
            grant = eReq && gnt;
            if (mOut && !rv && mDelay != 0)
                mDelay--;
            if (redir) begin
                q.delete();
                if (mOut && !rv) mStale = 1'b1;
                else             mOut   = 1'b0;
                mFetchPc = rpc;
            end else begin
                doPush = 1'b0;
                if (mOut && rv) begin
                    doPush = !mStale;
                    mOut   = 1'b0;
                end
                if (q.size() != 0 && ready)
                    void'(q.pop_front());
                if (doPush) begin
                    e.pc   = mReqPc;
                    e.inst = rdata;
                    q.push_back(e);
                end
                if (grant) begin
                    mOut     = 1'b1;
                    mStale   = 1'b0;
                    mReqPc   = mFetchPc;
                    mFetchPc = mFetchPc + 32'd4;
                    mDelay   = $urandom_range(3);
                end
            end
        end
    endtask

    vec_t vecs[16];

    initial begin
        RESET = 1'b1;
        applyStimulus(F, F, 32'h0, F, F, 32'h0);

        vecs[0]  = '{T, F, 32'h0,         T, F, 32'h0,   T, 32'h0,   F, 32'h0,   32'h0,         3'd0};
        vecs[1]  = '{T, T, 32'h1000_0000, T, F, 32'h0,   F, 32'h4,   F, 32'h0,   32'h0,         3'd0};
        vecs[2]  = '{T, F, 32'h0,         T, F, 32'h0,   T, 32'h4,   T, 32'h0,   32'h1000_0000, 3'd1};
        vecs[3]  = '{T, T, 32'h1000_0004, T, F, 32'h0,   F, 32'h8,   F, 32'h0,   32'h0,         3'd0};
        vecs[4]  = '{F, F, 32'h0,         F, F, 32'h0,   T, 32'h8,   T, 32'h4,   32'h1000_0004, 3'd1};
        vecs[5]  = '{F, T, 32'hDEAD_BEEF, F, F, 32'h0,   T, 32'h8,   T, 32'h4,   32'h1000_0004, 3'd1};
        vecs[6]  = '{T, F, 32'h0,         F, F, 32'h0,   T, 32'h8,   T, 32'h4,   32'h1000_0004, 3'd1};
        vecs[7]  = '{F, T, 32'h1000_0008, F, F, 32'h0,   F, 32'hC,   T, 32'h4,   32'h1000_0004, 3'd1};
        vecs[8]  = '{T, F, 32'h0,         T, T, 32'h100, F, 32'hC,   T, 32'h4,   32'h1000_0004, 3'd2};
        vecs[9]  = '{T, F, 32'h0,         T, F, 32'h0,   T, 32'h100, F, 32'h0,   32'h0,         3'd0};
        vecs[10] = '{T, F, 32'h0,         T, T, 32'h200, F, 32'h104, F, 32'h0,   32'h0,         3'd0};
        vecs[11] = '{T, F, 32'h0,         T, F, 32'h0,   F, 32'h200, F, 32'h0,   32'h0,         3'd0};
        vecs[12] = '{T, T, 32'hBAD0_0100, T, F, 32'h0,   F, 32'h200, F, 32'h0,   32'h0,         3'd0};
        vecs[13] = '{T, F, 32'h0,         T, F, 32'h0,   T, 32'h200, F, 32'h0,   32'h0,         3'd0};
        vecs[14] = '{F, T, 32'h1000_0200, F, F, 32'h0,   F, 32'h204, F, 32'h0,   32'h0,         3'd0};
        vecs[15] = '{F, F, 32'h0,         F, F, 32'h0,   T, 32'h204, T, 32'h200, 32'h1000_0200, 3'd1};

        doReset();
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            applyStimulus(vecs[i].gnt, vecs[i].rv, vecs[i].rdata,
                          vecs[i].ready, vecs[i].redir, vecs[i].rpc);
            #1;
            checkOutput($sformatf("vec%0d_req", i),   32'(Mem_req), 32'(vecs[i].eReq));
            checkOutput($sformatf("vec%0d_addr", i),  Mem_addr, vecs[i].eAddr);
            checkOutput($sformatf("vec%0d_valid", i), 32'(Inst_valid), 32'(vecs[i].eValid));
            checkOutput($sformatf("vec%0d_count", i), 32'(Count), 32'(vecs[i].eCount));
            if (vecs[i].eValid) begin
                checkOutput($sformatf("vec%0d_pc", i),   Inst_PC, vecs[i].ePc);
                checkOutput($sformatf("vec%0d_inst", i), Instruction, vecs[i].eInst);
            end
        end

        // Streaming with an always-ready consumer, then fill to full with decode stalled.
        doReset();
        runCycles(12, 100, 100, 0);
        doReset();
        runCycles(30, 100, 0, 0);
        @(negedge CLK);
        applyStimulus(T, F, 32'h0, F, F, 32'h0);
        #1;
        checkOutput("full_count", 32'(Count), 32'd4);
        checkOutput("full_req",   32'(Mem_req), 32'h0);
        checkOutput("full_addr",  Mem_addr, 32'h10);
        checkOutput("full_head",  Inst_PC, 32'h0);
        runCycles(8, 100, 100, 0);

        // Redirect coinciding with a response while two entries wait and decode is ready.
        doReset();
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK); applyStimulus(T, F, 32'h0, F, F, 32'h0);
            @(negedge CLK); applyStimulus(F, T, memWord(32'(4 * k)), F, F, 32'h0);
        end
        @(negedge CLK); applyStimulus(T, F, 32'h0, F, F, 32'h0);
        @(negedge CLK); applyStimulus(F, T, 32'hBADB_AD08, T, T, 32'h40);
        #1;
        checkOutput("rdr_pre_count", 32'(Count), 32'd2);
        checkOutput("rdr_pre_head",  Inst_PC, 32'h0);
        @(negedge CLK); applyStimulus(F, F, 32'h0, T, F, 32'h0);
        #1;
        checkOutput("rdr_count", 32'(Count), 32'd0);
        checkOutput("rdr_valid", 32'(Inst_valid), 32'd0);
        checkOutput("rdr_req",   32'(Mem_req), 32'd1);
        checkOutput("rdr_addr",  Mem_addr, 32'h40);
        @(negedge CLK); applyStimulus(T, F, 32'h0, F, F, 32'h0);
        @(negedge CLK); applyStimulus(F, T, memWord(32'h40), F, F, 32'h0);
        @(negedge CLK); applyStimulus(F, F, 32'h0, F, F, 32'h0);
        #1;
        checkOutput("rdr_new_pc",    Inst_PC, 32'h40);
        checkOutput("rdr_new_inst",  Instruction, memWord(32'h40));
        checkOutput("rdr_new_count", 32'(Count), 32'd1);

        // Grant withheld for five idle cycles, then accepted.
        doReset();
        runCycles(5, 0, 100, 0);
        runCycles(4, 100, 100, 0);

        // Asynchronous reset between edges while a request is outstanding.
        doReset();
        @(negedge CLK); applyStimulus(T, F, 32'h0, F, F, 32'h0);
        @(negedge CLK); applyStimulus(F, T, memWord(32'h0), F, F, 32'h0);
        @(negedge CLK); applyStimulus(T, F, 32'h0, F, F, 32'h0);
        @(negedge CLK); applyStimulus(F, F, 32'h0, F, F, 32'h0);
        #1;
        checkOutput("ar_pre_valid", 32'(Inst_valid), 32'd1);
        checkOutput("ar_pre_addr",  Mem_addr, 32'h8);
        RESET = 1'b1;
        #1;
        checkOutput("ar_valid", 32'(Inst_valid), 32'd0);
        checkOutput("ar_count", 32'(Count), 32'd0);
        checkOutput("ar_addr",  Mem_addr, 32'h0);
        checkOutput("ar_req",   32'(Mem_req), 32'd0);
        checkOutput("ar_pc",    Inst_PC, 32'h0);
        #1;
        RESET = 1'b0;
        @(negedge CLK); applyStimulus(F, T, 32'hBADB_AD04, F, F, 32'h0);
        #1;
        checkOutput("ar_req_after", 32'(Mem_req), 32'd1);
        @(negedge CLK); applyStimulus(T, F, 32'h0, F, F, 32'h0);
        #1;
        checkOutput("ar_ign_count", 32'(Count), 32'd0);
        checkOutput("ar_restart",   Mem_addr, 32'h0);
        @(negedge CLK); applyStimulus(F, T, memWord(32'h0), F, F, 32'h0);
        @(negedge CLK); applyStimulus(F, F, 32'h0, F, F, 32'h0);
        #1;
        checkOutput("ar_new_pc",   Inst_PC, 32'h0);
        checkOutput("ar_new_inst", Instruction, memWord(32'h0));

        // Long randomized run including redirects and address wrap-around.
        doReset();
        runCycles(3000, 60, 50, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
